// File: rtl/bin2bcd_seq.sv
// Sequential 20-bit binary to 6-digit packed BCD converter (double dabble, one bit per cycle).
// Define BCD_SAT_EN to saturate bcd_data to 999999 on overflow; otherwise the low six digits wrap.
module bin2bcd_seq #(
    parameter logic [23:0] INIT_BCD = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bin_vld,
    input  logic [19:0] bin_data,
    output logic        bin_rdy,
    output logic        bcd_vld,
    output logic [23:0] bcd_data,
    output logic        ovf,
    output logic [1:0]  fsm_state
);

    // Handshake: a value transfers on a rising clk edge where bin_vld && bin_rdy;
    // bin_rdy is high only in IDLE, and bcd_vld is a single-cycle result strobe.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [19:0] shift_q;
    logic [27:0] scratch_q;
    logic [4:0]  cnt_q;

    logic [27:0] adj;
    logic [27:0] scratch_n;
    logic [19:0] shift_n;

    assign fsm_state = state;

    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 7; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        {scratch_n, shift_n} = {adj, shift_q} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bin_rdy   <= 1'b1;
            bcd_vld   <= 1'b0;
            bcd_data  <= INIT_BCD;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bcd_vld <= 1'b0;
                    if (bin_vld && bin_rdy) begin
                        shift_q   <= bin_data;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        bin_rdy   <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q   <= shift_n;
                    scratch_q <= scratch_n;
                    cnt_q     <= cnt_q + 5'd1;
                    if (cnt_q == 5'd19) begin
                        // Result is taken from the final shift so it lands together with bcd_vld.
                        ovf     <= (scratch_n[27:24] != 4'd0);
`ifdef BCD_SAT_EN
                        bcd_data <= (scratch_n[27:24] != 4'd0) ? 24'h999999 : scratch_n[23:0];
`else
                        bcd_data <= scratch_n[23:0];
`endif
                        bcd_vld <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    bcd_vld <= 1'b0;
                    bin_rdy <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    bcd_vld <= 1'b0;
                    bin_rdy <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
